bit_scan_decoder: RTL and testbench
===================================

# bit_scan_decoder

Parametrised bit-serial scanner with a one-hot position decoder. On START it captures a WIDTH-bit input word. Each cycle it then steps an index through the word and drives a one-hot output for the current position when that bit is set. It adds the modes the fixed 8-bit counter/mux/decoder chain lacks: one-shot, continuous and skip-zero scanning, direction select, a stop/abort control, and explicit busy/last status for use by upstream sequencing logic.

## Interface
- WIDTH, 8: scanned word width; power of two, ≥2.
- IDX_W, $clog2(WIDTH): index width; derived, not overridden.
- CLK  in  1  sole clock; all state changes on posedge.
- RST_N  in  1  reset; synchronous, active-low, priority over all other inputs.
- START  in  1  begin a scan; sampled only when BUSY=0.
- STOP  in  1  abort the scan; sampled every cycle.
- MODE  in  2  00 one-shot, 01 continuous, 10 skip-zero, 11 reserved (acts as one-shot); captured on START.
- DIR  in  1  0 ascending (bit 0 first), 1 descending (bit WIDTH-1 first); captured on START.
- D  in  WIDTH  data word; captured on START, and at each wrap in continuous mode.
- O  out  WIDTH  one-hot of IDX when the captured bit D[IDX]=1, else all zero.
- IDX  out  IDX_W  current scan position.
- VALID  out  1  captured bit at IDX is 1; equals |O.
- LAST  out  1  final position of a one-shot or skip-zero pass.
- BUSY  out  1  scan in progress.

## Operation
- States:
  - IDLE: BUSY=0, O=0, VALID=0, LAST=0.
  - SCAN: BUSY=1.
- IDLE→SCAN: START=1 and STOP=0. The same edge captures D, MODE and DIR into shadow registers and loads IDX with the first position.
  - First position in one-shot and continuous modes: 0 when ascending, WIDTH-1 when descending.
  - First position in skip-zero mode: the first set bit in scan direction.
- One-shot: visits all WIDTH positions, stepping by ±1. LAST=1 on the final position. The next edge returns to IDLE.
- Continuous: visits all positions and wraps modulo WIDTH (WIDTH-1→0 ascending, 0→WIDTH-1 descending). The wrap edge re-captures D; MODE and DIR are not re-captured. LAST is never asserted. Leaves SCAN only on STOP.
- Skip-zero: IDX jumps straight to the next set bit in scan direction. The pass lasts popcount(D) cycles. LAST=1 on the final set bit.
  - Captured D=0: one SCAN cycle with IDX=first position, O=0, VALID=0, LAST=1.
- STOP=1 in SCAN: the next edge goes to IDLE and clears O, VALID, LAST; IDX holds.
- START and STOP together in IDLE: STOP wins, state stays IDLE.
- START while BUSY=1: ignored.
- D changing mid-pass has no effect until the next capture point.
- Reset values: state IDLE, O=0, IDX=0, VALID=0, LAST=0, BUSY=0, shadow D=0.

## Timing
- Every output is registered; there is no combinational path from any input to any output.
- Latency: START sampled at edge k → IDX, O, VALID and BUSY for the first position are valid after edge k.
- Each subsequent edge advances exactly one visited position.
- LAST is high for exactly one cycle, coincident with the final O. BUSY drops at the following edge.
- Back-to-back passes: a new START is accepted at the first edge where BUSY=0 is sampled, giving a minimum of one IDLE cycle between passes.
- RST_N=0 at any edge, including mid-scan, forces all reset values at that edge.

## Structure
- Package bit_scan_pkg holds:
  - the mode constants (MODE_ONESHOT, MODE_CONT, MODE_SKIP);
  - the state encoding (ST_IDLE, ST_SCAN);
  - a one-hot decode function parameterised by WIDTH.
- Sub-module bit_scan_next: combinational next-set-bit finder.
  - Inputs: shadow word, current IDX, DIR, and a "from start" flag.
  - Outputs: next index and a found flag.
  - Used for the skip-zero first-position and advance logic.
- Top level holds the FSM, shadow registers, index register and output registers.

## Test plan
- WIDTH=8, one-shot ascending, D=8'hAA → O sequence 00,02,00,08,00,20,00,80; IDX 0..7; LAST only with IDX=7; BUSY high for 8 cycles, then low.
- Skip-zero descending, D=8'hB4 → O sequence 80,20,10,04 with IDX 7,5,4,2; VALID=1 on all four; LAST with O=04; BUSY high for 4 cycles.
- Continuous ascending, D=8'hAA at START, D changed to 8'hB4 while IDX=3:
  - rest of the pass still follows 8'hAA;
  - after the wrap, O follows 8'hB4 (IDX 2 → O=04);
  - STOP at IDX=5 → next edge O=0, BUSY=0.
- Skip-zero with D=0 → one cycle with BUSY=1, VALID=0, LAST=1, O=0, then IDLE.
- Control and reset corner cases:
  - START pulsed while BUSY=1 → ignored;
  - START and STOP together in IDLE → stays IDLE;
  - MODE=11 → identical to one-shot;
  - RST_N=0 at IDX=4 mid-scan → next edge all outputs zero, BUSY=0, IDX=0.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// rtl/bit_scan_pkg.sv - shared modes, state encoding and one-hot decode for the bit scanner
package bit_scan_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_CONT    = 2'b01;
  localparam logic [1:0] MODE_SKIP    = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Widest word the decoder supports; callers truncate to their own WIDTH.
  localparam int ONEHOT_MAX_W = 64;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned pos);
    return ONEHOT_MAX_W'(1) << pos;
  endfunction

endpackage

// File: rtl/bit_scan_next.sv
// rtl/bit_scan_next.sv - combinational finder for the next set bit in scan direction
module bit_scan_next
  import bit_scan_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IDX_W-1:0] idx,
  input  logic             dir,
  input  logic             from_start,
  output logic [IDX_W-1:0] nxt,
  output logic             found
);

  // Loop runs away from the scan direction so the nearest qualifying bit wins.
  always_comb begin
    nxt   = dir ? IDX_W'(WIDTH - 1) : '0;
    found = 1'b0;
    if (dir) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (word[i] && (from_start || i < int'(idx))) begin
          nxt   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (word[i] && (from_start || i > int'(idx))) begin
          nxt   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bit_scan_decoder.sv
// rtl/bit_scan_decoder.sv - bit-serial scanner with one-hot position decode and busy/last status
module bit_scan_decoder
  import bit_scan_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic [IDX_W-1:0] IDX,
  output logic             VALID,
  output logic             LAST,
  output logic             BUSY
);

  state_t           state;
  logic [WIDTH-1:0] shadow_d;
  logic [1:0]       mode_r;
  logic             dir_r;

  logic             in_idle;
  logic [WIDTH-1:0] f_word;
  logic             f_dir;
  logic [IDX_W-1:0] f_idx;
  logic             f_found;

  logic [1:0]       n_mode;
  logic [IDX_W-1:0] first_pos;
  logic             wrap;
  logic [WIDTH-1:0] n_word;
  logic [IDX_W-1:0] n_idx;
  logic             more;
  logic             n_last;

  assign in_idle = (state == ST_IDLE);
  assign f_word  = in_idle ? D : shadow_d;
  assign f_dir   = in_idle ? DIR : dir_r;

  // In IDLE the finder looks at the incoming word for the first set bit;
  // in SCAN it looks past the current index in the captured word.
  bit_scan_next #(.WIDTH(WIDTH)) u_next (
    .word       (f_word),
    .idx        (IDX),
    .dir        (f_dir),
    .from_start (in_idle),
    .nxt        (f_idx),
    .found      (f_found)
  );

  always_comb begin
    n_mode    = in_idle ? MODE : mode_r;
    first_pos = f_dir ? IDX_W'(WIDTH - 1) : '0;
    wrap      = !in_idle && (mode_r == MODE_CONT) &&
                (IDX == (dir_r ? '0 : IDX_W'(WIDTH - 1)));
    n_word    = (in_idle || wrap) ? D : shadow_d;

    if (in_idle)
      n_idx = (n_mode == MODE_SKIP && f_found) ? f_idx : first_pos;
    else if (mode_r == MODE_SKIP)
      n_idx = f_found ? f_idx : IDX;
    else
      n_idx = dir_r ? IDX - IDX_W'(1) : IDX + IDX_W'(1);

    more = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (n_word[i] && (f_dir ? i < int'(n_idx) : i > int'(n_idx)))
        more = 1'b1;
    end

    case (n_mode)
      MODE_CONT: n_last = 1'b0;
      MODE_SKIP: n_last = !more;
      default:   n_last = (n_idx == (f_dir ? '0 : IDX_W'(WIDTH - 1)));
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      shadow_d <= '0;
      mode_r   <= MODE_ONESHOT;
      dir_r    <= 1'b0;
      IDX      <= '0;
      O        <= '0;
      VALID    <= 1'b0;
      LAST     <= 1'b0;
      BUSY     <= 1'b0;
    end else if (in_idle) begin
      if (START && !STOP) begin
        state    <= ST_SCAN;
        shadow_d <= D;
        mode_r   <= MODE;
        dir_r    <= DIR;
        IDX      <= n_idx;
        O        <= n_word[n_idx] ? WIDTH'(onehot(32'(n_idx))) : '0;
        VALID    <= n_word[n_idx];
        LAST     <= n_last;
        BUSY     <= 1'b1;
      end
    end else if (STOP || LAST) begin
      state <= ST_IDLE;
      O     <= '0;
      VALID <= 1'b0;
      LAST  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      if (wrap)
        shadow_d <= D;
      IDX   <= n_idx;
      O     <= n_word[n_idx] ? WIDTH'(onehot(32'(n_idx))) : '0;
      VALID <= n_word[n_idx];
      LAST  <= n_last;
    end
  end

endmodule

// File: tb/tb_bit_scan_decoder.sv
// tb/tb_bit_scan_decoder.sv - directed vector bench for bit_scan_decoder
module tb_bit_scan_decoder;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       STOP;
  logic [1:0] MODE;
  logic       DIR;
  logic [7:0] D;
  logic [7:0] O;
  logic [2:0] IDX;
  logic       VALID;
  logic       LAST;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       dir;
    logic [7:0] d;
    logic [7:0] o;
    logic [2:0] idx;
    logic       v;
    logic       l;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  bit_scan_decoder #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .STOP  (STOP),
    .MODE  (MODE),
    .DIR   (DIR),
    .D     (D),
    .O     (O),
    .IDX   (IDX),
    .VALID (VALID),
    .LAST  (LAST),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic s, input logic st, input logic [1:0] m, input logic dr,
                              input logic [7:0] dd, input logic [7:0] o, input logic [2:0] ix,
                              input logic v, input logic l, input logic b);
    vec_t r;
    r.start = s; r.stop = st; r.mode = m; r.dir = dr; r.d = dd;
    r.o = o; r.idx = ix; r.v = v; r.l = l; r.b = b;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic exp_all(input string tag, input logic [7:0] o, input logic [2:0] ix,
                         input logic v, input logic l, input logic b);
    chk($sformatf("%s.O", tag),     32'(O),     32'(o));
    chk($sformatf("%s.IDX", tag),   32'(IDX),   32'(ix));
    chk($sformatf("%s.VALID", tag), 32'(VALID), 32'(v));
    chk($sformatf("%s.LAST", tag),  32'(LAST),  32'(l));
    chk($sformatf("%s.BUSY", tag),  32'(BUSY),  32'(b));
  endtask

  task automatic step(input logic s, input logic st, input logic [1:0] m, input logic dr,
                      input logic [7:0] dd);
    START = s; STOP = st; MODE = m; DIR = dr; D = dd;
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] cont_o[10];
  logic [2:0] cont_i[10];

  initial begin
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 2'b00; DIR = 1'b0; D = 8'h00;
    step(0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'hFF);
    exp_all("reset", 8'h00, 3'd0, 0, 0, 0);
    RST_N = 1'b1;

    // one-shot ascending AA, with a START/D change mid-pass that must be ignored
    tbl.push_back(mk(1, 0, 0, 0, 8'hAA, 8'h00, 3'd0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'hAA, 8'h02, 3'd1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'hAA, 8'h00, 3'd2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 2, 1, 8'hFF, 8'h08, 3'd3, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 8'h00, 3'd4, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h20, 3'd5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'd6, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h80, 3'd7, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'd7, 0, 0, 0));
    // skip-zero descending B4
    tbl.push_back(mk(1, 0, 2, 1, 8'hB4, 8'h80, 3'd7, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h20, 3'd5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h10, 3'd4, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 3'd2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'd2, 0, 0, 0));
    // START with STOP in IDLE stays idle
    tbl.push_back(mk(1, 1, 0, 0, 8'hFF, 8'h00, 3'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'd2, 0, 0, 0));
    // reserved mode 11 behaves as one-shot, descending 81
    tbl.push_back(mk(1, 0, 3, 1, 8'h81, 8'h80, 3'd7, 1, 0, 1));
    for (int k = 6; k >= 1; k--)
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'(k), 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 3'd0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].dir, tbl[i].d);
      exp_all($sformatf("row%0d", i), tbl[i].o, tbl[i].idx, tbl[i].v, tbl[i].l, tbl[i].b);
    end

    // continuous ascending: AA until the wrap, B4 afterwards, then STOP at IDX=5
    step(1, 0, 1, 0, 8'hAA); exp_all("cont0", 8'h00, 3'd0, 0, 0, 1);
    step(0, 0, 0, 0, 8'hAA); exp_all("cont1", 8'h02, 3'd1, 1, 0, 1);
    step(0, 0, 0, 0, 8'hAA); exp_all("cont2", 8'h00, 3'd2, 0, 0, 1);
    step(0, 0, 0, 0, 8'hAA); exp_all("cont3", 8'h08, 3'd3, 1, 0, 1);
    cont_o = '{8'h00, 8'h20, 8'h00, 8'h80, 8'h00, 8'h00, 8'h04, 8'h00, 8'h10, 8'h20};
    cont_i = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 8'hB4);
      exp_all($sformatf("cont_b%0d", i), cont_o[i], cont_i[i], |cont_o[i], 0, 1);
    end
    step(0, 1, 0, 0, 8'hB4); exp_all("cont_stop", 8'h00, 3'd5, 0, 0, 0);

    // skip-zero with an empty word
    step(1, 0, 2, 0, 8'h00); exp_all("skip0", 8'h00, 3'd0, 0, 1, 1);
    step(0, 0, 0, 0, 8'h00); exp_all("skip0_end", 8'h00, 3'd0, 0, 0, 0);

    // reset mid-scan at IDX=4
    step(1, 0, 0, 0, 8'hFF); exp_all("rst_s0", 8'h01, 3'd0, 1, 0, 1);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 8'hFF);
    exp_all("rst_s4", 8'h10, 3'd4, 1, 0, 1);
    RST_N = 1'b0;
    step(0, 0, 0, 0, 8'hFF); exp_all("rst_mid", 8'h00, 3'd0, 0, 0, 0);
    RST_N = 1'b1;
    step(0, 0, 0, 0, 8'hFF); exp_all("rst_after", 8'h00, 3'd0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
